// File: rtl/decipher_pkg.sv
// Shared definitions for the AES inverse-cipher core.
// Holds the block/key widths, the FSM state encoding, the inverse S-box
// table and the GF(2^8) helpers used by InvSubBytes and InvMixColumns.
// Packing: byte i of a block lives in bits [8i+7:8i]. Word w lives in
// [32w+31:32w], so a 32-bit word is one state column.
package decipher_pkg;

  localparam int BLK_S          = 128;
  localparam int NB             = 4;
  localparam int ROUND_KEY_BITS = 128;
  localparam int BYTE_S         = 8;
  localparam int WORD_S         = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_INIT,
    ST_ROUND,
    ST_FINAL
  } state_t;

  // Inverse S-box, row-major: entry 0 sits in the top byte and entry 255 in the bottom byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [BYTE_S-1:0] get_inv_sbox(input logic [BYTE_S-1:0] b);
    return INV_SBOX_TBL[2047 - BYTE_S * int'(b) -: BYTE_S];
  endfunction

  function automatic logic [BYTE_S-1:0] get_byte(input logic [BLK_S-1:0] blk, input int idx);
    return blk[BYTE_S * idx +: BYTE_S];
  endfunction

  function automatic logic [WORD_S-1:0] get_word(input logic [BLK_S-1:0] blk, input int idx);
    return blk[WORD_S * idx +: WORD_S];
  endfunction

  // Multiply by x. The reduction polynomial is x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_S-1:0] xtime(input logic [BYTE_S-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_S-1:0] gm9(input logic [BYTE_S-1:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [BYTE_S-1:0] gm11(input logic [BYTE_S-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [BYTE_S-1:0] gm13(input logic [BYTE_S-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [BYTE_S-1:0] gm14(input logic [BYTE_S-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // One column through the {0e,0b,0d,09} circulant matrix.
  function automatic logic [WORD_S-1:0] inv_mix_column(input logic [WORD_S-1:0] col);
    logic [BYTE_S-1:0] a0, a1, a2, a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3),
            gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3),
            gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
            gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3)};
  endfunction

endpackage

// File: rtl/decipher_if.sv
// Bundles the command, result and key-store signals of the inverse-cipher core.
//   en, ciphertext, rounds_total : start request with its block and round count
//   key                          : round key read from the expanded-key store
//   plaintext, en_o              : result block with its one-cycle valid pulse
//   round_key_no                 : index of the round key requested from the store
//   busy                         : a block is in flight
// The master modport is the command/key-store side. The slave modport is the core.
interface decipher_if;
  import decipher_pkg::*;

  logic                      en;
  logic [BLK_S-1:0]          ciphertext;
  logic [NB-1:0]             rounds_total;
  logic [ROUND_KEY_BITS-1:0] key;
  logic [BLK_S-1:0]          plaintext;
  logic [NB-1:0]             round_key_no;
  logic                      busy;
  logic                      en_o;

  modport master (
    output en, ciphertext, rounds_total, key,
    input  plaintext, round_key_no, busy, en_o
  );

  modport slave (
    input  en, ciphertext, rounds_total, key,
    output plaintext, round_key_no, busy, en_o
  );

endinterface

// File: rtl/decipher_inv_round.sv
// One combinational AES inverse round.
// The round applies InvShiftRows, InvSubBytes and AddRoundKey, then InvMixColumns.
// InvMixColumns is skipped when last=1 for the final round.
//   state_in  : current cipher state
//   round_key : round key for this round
//   last      : 1 = final round, so no InvMixColumns
//   state_out : next cipher state
module decipher_inv_round
  import decipher_pkg::*;
(
  input  logic [BLK_S-1:0]          state_in,
  input  logic [ROUND_KEY_BITS-1:0] round_key,
  input  logic                      last,
  output logic [BLK_S-1:0]          state_out
);

  logic [BLK_S-1:0] shifted;
  logic [BLK_S-1:0] subbed;
  logic [BLK_S-1:0] keyed;
  logic [BLK_S-1:0] mixed;

  // Row r rotates right by r columns. Byte (r,c) comes from column (c-r) mod 4.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[BYTE_S * (4 * c + r) +: BYTE_S] = get_byte(state_in, 4 * ((c - r + 4) % 4) + r);
      end
    end
  end

  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[BYTE_S * i +: BYTE_S] = get_inv_sbox(get_byte(shifted, i));
    end
  end

  assign keyed = subbed ^ round_key;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[WORD_S * c +: WORD_S] = inv_mix_column(get_word(keyed, c));
    end
  end

  assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/decipher.sv
// Iterative AES inverse cipher. It decrypts one 128-bit block and does one round per clock.
// Round keys are requested from an external expanded-key store in the order Nr down to 0.
// The store answers one cycle after the request.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-low
//   bus   : decipher_if slave. It carries en, ciphertext, rounds_total and key in,
//           and plaintext, round_key_no, busy and en_o out.
// Latency from an accepted en to en_o is Nr+3 cycles. en is taken again in the en_o cycle.
module decipher
  import decipher_pkg::*;
(
  input logic       clk,
  input logic       reset,
  decipher_if.slave bus
);

  state_t           state_q, state_d;
  logic [BLK_S-1:0] blk_q, blk_d;
  logic [BLK_S-1:0] pt_q, pt_d;
  logic [NB-1:0]    rkn_q, rkn_d;
  logic             busy_q, busy_d;
  logic             en_o_q, en_o_d;
  logic [BLK_S-1:0] round_out;
  logic             last_round;

  assign last_round = (state_q == ST_FINAL);

  decipher_inv_round u_inv_round (
    .state_in  (blk_q),
    .round_key (bus.key),
    .last      (last_round),
    .state_out (round_out)
  );

  // State register. Reset aborts any block in flight and clears every output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      pt_q    <= '0;
      rkn_q   <= '0;
      busy_q  <= 1'b0;
      en_o_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      pt_q    <= pt_d;
      rkn_q   <= rkn_d;
      busy_q  <= busy_d;
      en_o_q  <= en_o_d;
    end
  end

  // Next-state and datapath logic.
  // The key index runs one cycle ahead of its use, so in INIT/ROUND an index of 0 means K[0] arrives next.
  // That is the cue to go to FINAL, and it also lets Nr<=1 skip ROUND altogether.
  // The index never drops below 0.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    pt_d    = pt_q;
    busy_d  = busy_q;
    en_o_d  = 1'b0;
    rkn_d   = (rkn_q == '0) ? '0 : rkn_q - NB'(1);

    case (state_q)
      ST_IDLE: begin
        rkn_d = '0;
        if (bus.en) begin
          blk_d   = bus.ciphertext;
          rkn_d   = bus.rounds_total;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        blk_d   = blk_q ^ bus.key;
        state_d = (rkn_q == '0) ? ST_FINAL : ST_ROUND;
      end
      ST_ROUND: begin
        blk_d = round_out;
        if (rkn_q == '0) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        pt_d    = round_out;
        en_o_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.plaintext    = pt_q;
  assign bus.round_key_no = rkn_q;
  assign bus.busy         = busy_q;
  assign bus.en_o         = en_o_q;

endmodule
